gate_truth_checker: RTL

- Hardware-side counterpart to the gate stimulus/monitor bench flow. Instead of a bench driving a/b and printing results, this block drives the two gate operands itself.
- It waits a settle interval, samples the five gate outputs (Nand, Not, And, Or, Xor) and compares them with the golden truth table. It accumulates error statistics over one full 4-vector sweep.
- It sits beside the gate library as a reusable self-checking harness, so gate regressions report pass/fail without reading $monitor output.

---
 rtl/gate_truth_checker.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gate_truth_checker.sv
// Self-checking harness for the basic gate library: drives the a/b operands
// through a 4-vector sweep, samples the five gate outputs and accumulates errors.
module gate_truth_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       nand_in,
  input  logic       not_in,
  input  logic       and_in,
  input  logic       or_in,
  input  logic       xor_in,
  output logic [1:0] vec,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [4:0] err_mask
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  // Number of set bits in a 5-bit mismatch vector.
  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'd0, v[i]};
    end
    return n;
  endfunction

  // Add a small increment to the error count, clamping at 255.
  function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [2:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {6'd0, inc};
    return sum[8] ? 8'd255 : sum[7:0];
  endfunction

  state_t     state_r, state_s;
  logic [3:0] cnt_r, cnt_s;
  logic [1:0] vec_r, vec_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       pass_r, pass_s;
  logic [7:0] errc_r, errc_s;
  logic [4:0] errm_r, errm_s;
  logic [4:0] mism_s;

  assign a         = vec_r[0];
  assign b         = vec_r[1];
  assign vec       = vec_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = errc_r;
  assign err_mask  = errm_r;

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    vec_s   = vec_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    pass_s  = pass_r;
    errc_s  = errc_r;
    errm_s  = errm_r;

    // Case inequality so an X/Z gate output is reported as a failure.
    mism_s[0] = (nand_in !== ~(vec_r[0] & vec_r[1]));
    mism_s[1] = (not_in  !== ~vec_r[0]);
    mism_s[2] = (and_in  !== (vec_r[0] & vec_r[1]));
    mism_s[3] = (or_in   !== (vec_r[0] | vec_r[1]));
    mism_s[4] = (xor_in  !== (vec_r[0] ^ vec_r[1]));

    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_SETTLE;
          cnt_s   = 4'd0;
          vec_s   = 2'd0;
          busy_s  = 1'b1;
          pass_s  = 1'b0;
          errc_s  = 8'd0;
          errm_s  = 5'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SETTLE: begin
        cnt_s = cnt_r + 4'd1;
        if (cnt_r == SETTLE_LAST) begin
          state_s = S_SAMPLE;
        end else begin
          state_s = S_SETTLE;
        end
      end
      S_SAMPLE: begin
        errm_s = errm_r | mism_s;
        errc_s = sat_add(errc_r, popcount5(mism_s));
        if (vec_r == 2'd3) begin
          state_s = S_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (errc_s == 8'd0);
        end else begin
          state_s = S_SETTLE;
          vec_s   = vec_r + 2'd1;
          cnt_s   = 4'd0;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
      vec_r   <= 2'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      errc_r  <= 8'd0;
      errm_r  <= 5'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      vec_r   <= vec_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
      errc_r  <= errc_s;
      errm_r  <= errm_s;
    end
  end

endmodule
